// File: rtl/frame_scheduler_pkg.sv
// Shared constants for the playback frame scheduler: header and point-word layout,
// default widths and the scheduler state encoding.
package frame_scheduler_pkg;

    localparam int FS_ADDR_W = 13;
    localparam int FS_CNT_W  = 13;
    localparam int FS_DATA_W = 46;

    // Header word: {next, npts, rep}
    localparam int HDR_REP_LSB  = 0;
    localparam int HDR_NPTS_LSB = 13;
    localparam int HDR_NEXT_LSB = 26;

    // Point word: {colour, x, y, z}
    localparam int PT_Z_LSB      = 0;
    localparam int PT_Y_LSB      = 13;
    localparam int PT_X_LSB      = 26;
    localparam int PT_AXIS_W     = 13;
    localparam int PT_COLOUR_LSB = 39;
    localparam int PT_COLOUR_W   = 7;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_HDR_WAIT,
        FS_HDR_LATCH,
        FS_PT_IDLE,
        FS_PT_WAIT,
        FS_PT_OUT,
        FS_PASS_END
    } fsched_state_e;

endpackage

// File: rtl/frame_scheduler_if.sv
// Bundle of the scheduler's control, RAM-read and point-delivery signals.
// master = the scheduler, slave = the surrounding RAM / consumer / decoder.
interface frame_scheduler_if
    import frame_scheduler_pkg::*;
#(
    parameter int ADDR_W = FS_ADDR_W,
    parameter int DATA_W = FS_DATA_W
);
    logic              enable_i;
    logic [ADDR_W-1:0] ram_rdaddr_o;
    logic [DATA_W-1:0] ram_q_i;
    logic              pt_req_i;
    logic              pt_valid_o;
    logic [DATA_W-1:0] pt_data_o;
    logic              frame_latch_o;
    logic              frame_advance_o;
    logic              empty_frame_o;
    logic              req_overrun_o;
    logic              busy_o;

    modport master (
        input  enable_i, ram_q_i, pt_req_i,
        output ram_rdaddr_o, pt_valid_o, pt_data_o, frame_latch_o,
               frame_advance_o, empty_frame_o, req_overrun_o, busy_o
    );

    modport slave (
        output enable_i, ram_q_i, pt_req_i,
        input  ram_rdaddr_o, pt_valid_o, pt_data_o, frame_latch_o,
               frame_advance_o, empty_frame_o, req_overrun_o, busy_o
    );
endinterface

// File: rtl/frame_scheduler.sv
// Walks frame records in the position/colour RAM, replays each frame rep+1 times,
// follows next-frame links and hands one point to the phase path per request.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int ADDR_W  = FS_ADDR_W,
    parameter int CNT_W   = FS_CNT_W,
    parameter int DATA_W  = FS_DATA_W,
    parameter int RAM_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    frame_scheduler_if.master   bus
);

    localparam logic [1:0]        LAT_LAST = 2'(RAM_LAT - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);

    fsched_state_e     state_q, state_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
    logic [ADDR_W-1:0] hdr_addr_q, hdr_addr_d;
    logic [ADDR_W-1:0] next_q, next_d;
    logic [CNT_W-1:0]  rep_q, rep_d;
    logic [CNT_W-1:0]  npts_q, npts_d;
    logic [CNT_W-1:0]  pt_cnt_q, pt_cnt_d;
    logic              pt_valid_q, pt_valid_d;
    logic [DATA_W-1:0] pt_data_q, pt_data_d;
    logic              latch_q, latch_d;
    logic              advance_q, advance_d;
    logic              empty_q, empty_d;
    logic              overrun_q, overrun_d;
    logic              busy_q, busy_d;

    logic [CNT_W-1:0]  hdr_rep, hdr_npts;
    logic [ADDR_W-1:0] hdr_next;

    assign hdr_rep  = bus.ram_q_i[HDR_REP_LSB  +: CNT_W];
    assign hdr_npts = bus.ram_q_i[HDR_NPTS_LSB +: CNT_W];
    assign hdr_next = bus.ram_q_i[HDR_NEXT_LSB +: ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FS_IDLE;
            wait_q     <= '0;
            rdaddr_q   <= '0;
            hdr_addr_q <= '0;
            next_q     <= '0;
            rep_q      <= '0;
            npts_q     <= '0;
            pt_cnt_q   <= '0;
            pt_valid_q <= 1'b0;
            pt_data_q  <= '0;
            latch_q    <= 1'b0;
            advance_q  <= 1'b0;
            empty_q    <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_q     <= wait_d;
            rdaddr_q   <= rdaddr_d;
            hdr_addr_q <= hdr_addr_d;
            next_q     <= next_d;
            rep_q      <= rep_d;
            npts_q     <= npts_d;
            pt_cnt_q   <= pt_cnt_d;
            pt_valid_q <= pt_valid_d;
            pt_data_q  <= pt_data_d;
            latch_q    <= latch_d;
            advance_q  <= advance_d;
            empty_q    <= empty_d;
            overrun_q  <= overrun_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        rdaddr_d   = rdaddr_q;
        hdr_addr_d = hdr_addr_q;
        next_d     = next_q;
        rep_d      = rep_q;
        npts_d     = npts_q;
        pt_cnt_d   = pt_cnt_q;
        pt_valid_d = 1'b0;
        pt_data_d  = pt_data_q;
        latch_d    = 1'b0;
        advance_d  = 1'b0;
        empty_d    = 1'b0;
        overrun_d  = overrun_q | (bus.pt_req_i && (state_q != FS_PT_IDLE));

        if (!bus.enable_i) begin
            state_d    = FS_IDLE;
            wait_d     = '0;
            rdaddr_d   = '0;
            hdr_addr_d = '0;
            overrun_d  = 1'b0;
        end else begin
            unique case (state_q)
                FS_IDLE: begin
                    state_d  = FS_HDR_WAIT;
                    wait_d   = '0;
                    rdaddr_d = hdr_addr_q;
                end
                FS_HDR_WAIT: begin
                    if (wait_q == LAT_LAST) begin
                        state_d = FS_HDR_LATCH;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                FS_HDR_LATCH: begin
                    rep_d    = hdr_rep;
                    npts_d   = hdr_npts;
                    next_d   = hdr_next;
                    pt_cnt_d = '0;
                    if (hdr_npts == '0) begin
                        empty_d    = 1'b1;
                        advance_d  = 1'b1;
                        hdr_addr_d = hdr_next;
                        rdaddr_d   = hdr_next;
                        wait_d     = '0;
                        state_d    = FS_HDR_WAIT;
                    end else begin
                        rdaddr_d = hdr_addr_q + ONE_A;
                        state_d  = FS_PT_IDLE;
                    end
                end
                FS_PT_IDLE: begin
                    if (bus.pt_req_i) begin
                        state_d = FS_PT_WAIT;
                        wait_d  = '0;
                    end
                end
                FS_PT_WAIT: begin
                    // Strobe is registered on entry to PT_OUT so it lands RAM_LAT+1 after the request.
                    if (wait_q == LAT_LAST) begin
                        state_d    = FS_PT_OUT;
                        wait_d     = '0;
                        pt_valid_d = 1'b1;
                        pt_data_d  = bus.ram_q_i;
                    end else begin
                        wait_d = wait_q + 2'd1;
                    end
                end
                FS_PT_OUT: begin
                    pt_cnt_d = pt_cnt_q + ONE_C;
                    if (pt_cnt_q == npts_q - ONE_C) begin
                        state_d = FS_PASS_END;
                    end else begin
                        rdaddr_d = rdaddr_q + ONE_A;
                        state_d  = FS_PT_IDLE;
                    end
                end
                FS_PASS_END: begin
                    latch_d = 1'b1;
                    if (rep_q == '0) begin
                        advance_d  = 1'b1;
                        hdr_addr_d = next_q;
                        rdaddr_d   = next_q;
                        wait_d     = '0;
                        state_d    = FS_HDR_WAIT;
                    end else begin
                        rep_d    = rep_q - ONE_C;
                        rdaddr_d = hdr_addr_q + ONE_A;
                        pt_cnt_d = '0;
                        state_d  = FS_PT_IDLE;
                    end
                end
                default: state_d = FS_IDLE;
            endcase
        end

        busy_d = (state_d != FS_IDLE);
    end

    assign bus.ram_rdaddr_o    = rdaddr_q;
    assign bus.pt_valid_o      = pt_valid_q;
    assign bus.pt_data_o       = pt_data_q;
    assign bus.frame_latch_o   = latch_q;
    assign bus.frame_advance_o = advance_q;
    assign bus.empty_frame_o   = empty_q;
    assign bus.req_overrun_o   = overrun_q;
    assign bus.busy_o          = busy_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Directed bench: two schedulers (RAM latency 1 and 3) share one memory image,
// enable, request and reset, and are checked against hand-computed values.
module tb_frame_scheduler;
    import frame_scheduler_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic pt_req = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    logic [45:0] mem [0:8191];

    frame_scheduler_if #(.ADDR_W(13), .DATA_W(46)) bus1 ();
    frame_scheduler_if #(.ADDR_W(13), .DATA_W(46)) bus3 ();

    frame_scheduler #(.ADDR_W(13), .CNT_W(13), .DATA_W(46), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    frame_scheduler #(.ADDR_W(13), .CNT_W(13), .DATA_W(46), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    assign bus1.enable_i = enable;
    assign bus3.enable_i = enable;
    assign bus1.pt_req_i = pt_req;
    assign bus3.pt_req_i = pt_req;

    // Behavioural RAMs: latency 1 and a 3-stage read pipeline
    logic [45:0] q1;
    logic [45:0] p3 [3];
    always @(posedge clk) begin
        q1    <= mem[bus1.ram_rdaddr_o];
        p3[0] <= mem[bus3.ram_rdaddr_o];
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign bus1.ram_q_i = q1;
    assign bus3.ram_q_i = p3[2];

    int n_latch1 = 0, n_latch3 = 0, n_adv1 = 0, n_adv3 = 0;
    int n_empty1 = 0, n_empty3 = 0, n_valid1 = 0, n_valid3 = 0;
    always @(negedge clk) begin
        if (bus1.frame_latch_o)   n_latch1 <= n_latch1 + 1;
        if (bus3.frame_latch_o)   n_latch3 <= n_latch3 + 1;
        if (bus1.frame_advance_o) n_adv1   <= n_adv1 + 1;
        if (bus3.frame_advance_o) n_adv3   <= n_adv3 + 1;
        if (bus1.empty_frame_o)   n_empty1 <= n_empty1 + 1;
        if (bus3.empty_frame_o)   n_empty3 <= n_empty3 + 1;
        if (bus1.pt_valid_o)      n_valid1 <= n_valid1 + 1;
        if (bus3.pt_valid_o)      n_valid3 <= n_valid3 + 1;
    end

    function automatic logic [45:0] hdr(input int rep, input int npts, input int nxt);
        logic [12:0] r, n, x;
        r = 13'(rep);
        n = 13'(npts);
        x = 13'(nxt);
        return {7'd0, x, n, r};
    endfunction

    function automatic logic [45:0] word(input int i);
        return 46'h2A_0000_0000 + 46'(i * 17);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request pulse; waits (bounded) for the strobe on both instances
    task automatic get_pt(output logic [45:0] d1, output logic [45:0] d3,
                          output int l1, output int l3);
        l1 = -1;
        l3 = -1;
        d1 = '0;
        d3 = '0;
        pt_req = 1'b1;
        cyc(1);
        pt_req = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus1.pt_valid_o && l1 < 0) begin d1 = bus1.pt_data_o; l1 = c; end
            if (bus3.pt_valid_o && l3 < 0) begin d3 = bus3.pt_data_o; l3 = c; end
            if (l1 >= 0 && l3 >= 0) break;
            cyc(1);
        end
    endtask

    task automatic check_pt(input string tag, input logic [45:0] exp);
        logic [45:0] d1, d3;
        int l1, l3;
        get_pt(d1, d3, l1, l3);
        $display("pt %s: lat1=%0d data1=%h lat3=%0d data3=%h exp=%h", tag, l1, d1, l3, d3, exp);
        chk({tag, " data lat1"}, 64'(d1), 64'(exp));
        chk({tag, " data lat3"}, 64'(d3), 64'(exp));
        chk({tag, " latency lat1"}, 64'(l1), 64'd2);
        chk({tag, " latency lat3"}, 64'(l3), 64'd4);
    endtask

    task automatic restart();
        enable = 1'b0;
        cyc(2);
    endtask

    initial begin
        int bl1, bl3, ba1, ba3, be1, be3, bv1, bv3;
        int t1 [3];
        int t3 [3];
        logic [45:0] dd1 [3];
        int k1, k3;

        for (int i = 0; i < 8192; i++) mem[i] = word(i);

        // Reset state
        cyc(3);
        chk("reset rdaddr1", 64'(bus1.ram_rdaddr_o), 64'd0);
        chk("reset rdaddr3", 64'(bus3.ram_rdaddr_o), 64'd0);
        chk("reset busy1", 64'(bus1.busy_o), 64'd0);
        chk("reset valid1", 64'(bus1.pt_valid_o), 64'd0);
        chk("reset data1", 64'(bus1.pt_data_o), 64'd0);
        chk("reset overrun3", 64'(bus3.req_overrun_o), 64'd0);
        rst = 1'b0;
        cyc(2);

        // 1: single pass of three points, link back to itself
        mem[0] = hdr(0, 3, 0);
        bl1 = n_latch1; bl3 = n_latch3; ba1 = n_adv1; ba3 = n_adv3;
        enable = 1'b1;
        cyc(8);
        chk("t1 busy1", 64'(bus1.busy_o), 64'd1);
        for (int k = 1; k <= 3; k++) begin
            check_pt($sformatf("t1 p%0d", k), word(k));
            cyc(8);
        end
        chk("t1 latch1", 64'(n_latch1 - bl1), 64'd1);
        chk("t1 latch3", 64'(n_latch3 - bl3), 64'd1);
        chk("t1 adv1", 64'(n_adv1 - ba1), 64'd1);
        chk("t1 adv3", 64'(n_adv3 - ba3), 64'd1);
        check_pt("t1 loop", word(1));
        chk("t1 overrun1", 64'(bus1.req_overrun_o), 64'd0);

        // 2: repeated frame
        restart();
        mem[0] = hdr(2, 2, 0);
        bl1 = n_latch1; bl3 = n_latch3; ba1 = n_adv1; ba3 = n_adv3;
        enable = 1'b1;
        cyc(8);
        for (int k = 0; k < 6; k++) begin
            check_pt($sformatf("t2 p%0d", k), word((k % 2) + 1));
            cyc(8);
        end
        chk("t2 latch1", 64'(n_latch1 - bl1), 64'd3);
        chk("t2 latch3", 64'(n_latch3 - bl3), 64'd3);
        chk("t2 adv1", 64'(n_adv1 - ba1), 64'd1);
        chk("t2 adv3", 64'(n_adv3 - ba3), 64'd1);

        // 3: empty header skipped to a linked frame
        restart();
        mem[0]  = hdr(0, 0, 10);
        mem[10] = hdr(0, 1, 10);
        be1 = n_empty1; be3 = n_empty3; ba1 = n_adv1; ba3 = n_adv3;
        enable = 1'b1;
        cyc(12);
        check_pt("t3 p0", word(11));
        cyc(8);
        chk("t3 empty1", 64'(n_empty1 - be1), 64'd1);
        chk("t3 empty3", 64'(n_empty3 - be3), 64'd1);
        chk("t3 adv1", 64'(n_adv1 - ba1), 64'd2);
        chk("t3 adv3", 64'(n_adv3 - ba3), 64'd2);

        // 4: request held high
        restart();
        mem[0] = hdr(0, 4, 0);
        enable = 1'b1;
        cyc(8);
        k1 = 0;
        k3 = 0;
        pt_req = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            cyc(1);
            if (bus1.pt_valid_o && k1 < 3) begin t1[k1] = c; dd1[k1] = bus1.pt_data_o; k1++; end
            if (bus3.pt_valid_o && k3 < 3) begin t3[k3] = c; k3++; end
        end
        pt_req = 1'b0;
        $display("held req: lat1 strobes at %0d %0d %0d, lat3 strobes at %0d %0d %0d",
                 t1[0], t1[1], t1[2], t3[0], t3[1], t3[2]);
        chk("t4 count1", 64'(k1), 64'd3);
        chk("t4 count3", 64'(k3), 64'd3);
        chk("t4 first1", 64'(t1[0]), 64'd2);
        chk("t4 gap1a", 64'(t1[1] - t1[0]), 64'd3);
        chk("t4 gap1b", 64'(t1[2] - t1[1]), 64'd3);
        chk("t4 gap3a", 64'(t3[1] - t3[0]), 64'd5);
        chk("t4 gap3b", 64'(t3[2] - t3[1]), 64'd5);
        chk("t4 data1", 64'(dd1[2]), 64'(word(3)));
        chk("t4 overrun1", 64'(bus1.req_overrun_o), 64'd1);
        chk("t4 overrun3", 64'(bus3.req_overrun_o), 64'd1);
        enable = 1'b0;
        cyc(1);
        chk("t4 overrun clr1", 64'(bus1.req_overrun_o), 64'd0);
        chk("t4 overrun clr3", 64'(bus3.req_overrun_o), 64'd0);

        // 5: enable dropped while a point read is pending
        cyc(1);
        enable = 1'b1;
        cyc(8);
        pt_req = 1'b1;
        cyc(1);
        pt_req = 1'b0;
        enable = 1'b0;
        bv1 = n_valid1; bv3 = n_valid3;
        cyc(1);
        $display("abort: rdaddr1=%0d busy1=%0d rdaddr3=%0d busy3=%0d",
                 bus1.ram_rdaddr_o, bus1.busy_o, bus3.ram_rdaddr_o, bus3.busy_o);
        chk("t5 rdaddr1", 64'(bus1.ram_rdaddr_o), 64'd0);
        chk("t5 rdaddr3", 64'(bus3.ram_rdaddr_o), 64'd0);
        chk("t5 busy1", 64'(bus1.busy_o), 64'd0);
        chk("t5 busy3", 64'(bus3.busy_o), 64'd0);
        cyc(5);
        chk("t5 novalid1", 64'(n_valid1 - bv1), 64'd0);
        chk("t5 novalid3", 64'(n_valid3 - bv3), 64'd0);
        enable = 1'b1;
        cyc(8);
        check_pt("t5 restart", word(1));

        // 6: header at the top address, points wrap to 0 and 1; then async reset
        restart();
        mem[0]    = hdr(0, 0, 8191);
        mem[8191] = hdr(0, 2, 8191);
        enable = 1'b1;
        cyc(12);
        check_pt("t6 p0", hdr(0, 0, 8191));
        cyc(4);
        check_pt("t6 p1", word(1));
        cyc(2);
        rst = 1'b1;
        #1;
        chk("t6 rst rdaddr3", 64'(bus3.ram_rdaddr_o), 64'd0);
        chk("t6 rst busy1", 64'(bus1.busy_o), 64'd0);
        chk("t6 rst busy3", 64'(bus3.busy_o), 64'd0);
        chk("t6 rst data1", 64'(bus1.pt_data_o), 64'd0);
        chk("t6 rst data3", 64'(bus3.pt_data_o), 64'd0);
        enable = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
